// File: rtl/div_seq_ctrl_if.sv
// Request, divider and result signals of the division sequencer.
// slave: the sequencer itself; master: the environment around it
// (request source, iterative divider and result consumer).
interface div_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [3:0]  in_tag;
  logic        div_start;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic        div_busy;
  logic [31:0] div_z;
  logic [31:0] div_r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [31:0] out_r;
  logic [3:0]  out_tag;
  logic        out_dz;

  modport slave (
    input  in_valid, in_x, in_y, in_tag, div_busy, div_z, div_r, out_ready,
    output in_ready, div_start, div_x, div_y, out_valid, out_z, out_r, out_tag, out_dz
  );

  modport master (
    output in_valid, in_x, in_y, in_tag, div_busy, div_z, div_r, out_ready,
    input  in_ready, div_start, div_x, div_y, out_valid, out_z, out_r, out_tag, out_dz
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for an iterative sign-magnitude divider: accepts a request,
// launches the divider, waits for its busy flag to rise and fall, and
// queues the result in a 2-entry FIFO. Zero divisors are answered
// directly without touching the divider.
//
// state   | meaning
// IDLE    | waiting for a request (ready only if FIFO has space)
// LAUNCH  | div_start pulse cycle
// WAIT_HI | waiting for divider busy to be seen high
// WAIT_LO | waiting for busy low, then capture result
module div_seq_ctrl (
  input  logic          clk,
  input  logic          rst,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

  typedef struct packed {
    logic [31:0] z;
    logic [31:0] r;
    logic [3:0]  tag;
    logic        dz;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [3:0]  tag_q, tag_d;
  entry_t      mem_q [2];
  entry_t      mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        in_ready_w;
  logic        div_start_w;
  logic        push;
  logic        pop;
  entry_t      push_entry;

  // Sign-magnitude has two zeros; only +0 ever leaves this block.
  function automatic logic [31:0] no_neg_zero(input logic [31:0] v);
    return (v[30:0] == 31'd0) ? 32'd0 : v;
  endfunction

  // Next-state, operand capture and result-push decision.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    tag_d       = tag_q;
    push        = 1'b0;
    push_entry  = '0;
    div_start_w = 1'b0;
    in_ready_w  = (state_q == IDLE) && (count_q != 2'd2);
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          x_d   = bus.in_x;
          y_d   = bus.in_y;
          tag_d = bus.in_tag;
          if (bus.in_y[30:0] == 31'd0) begin
            push           = 1'b1;
            push_entry.z   = {bus.in_x[31] ^ bus.in_y[31], 31'h7FFFFFFF};
            push_entry.r   = no_neg_zero(bus.in_x);
            push_entry.tag = bus.in_tag;
            push_entry.dz  = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        div_start_w = 1'b1;
        state_d     = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.div_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!bus.div_busy) begin
          push           = 1'b1;
          push_entry.z   = no_neg_zero(bus.div_z);
          push_entry.r   = no_neg_zero(bus.div_r);
          push_entry.tag = tag_q;
          push_entry.dz  = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result FIFO bookkeeping; a push never meets a full buffer because
  // requests are only accepted while there is space.
  always_comb begin
    pop              = (count_q != 2'd0) && bus.out_ready;
    mem_d            = mem_q;
    if (push) mem_d[wr_ptr_q] = push_entry;
    wr_ptr_d         = wr_ptr_q ^ push;
    rd_ptr_d         = rd_ptr_q ^ pop;
    count_d          = count_q + {1'b0, push} - {1'b0, pop};
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      tag_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tag_q    <= tag_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.div_start = div_start_w;
  assign bus.div_x     = x_q;
  assign bus.div_y     = y_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_z     = mem_q[rd_ptr_q].z;
  assign bus.out_r     = mem_q[rd_ptr_q].r;
  assign bus.out_tag   = mem_q[rd_ptr_q].tag;
  assign bus.out_dz    = mem_q[rd_ptr_q].dz;

endmodule
